// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed four-digit seven-segment scan engine.
//   Drives one digit at a time for REFRESH_DIV clocks, showing the timer's
//   BCD digits with a minutes/seconds decimal point, dashes on error, and a
//   blinking display once the countdown is done.
// Ports:
//   clk    - system clock, rising edge
//   reset  - asynchronous active-low reset (0 = reset)
//   D0..D3 - BCD digits, D0 rightmost (seconds units), D3 leftmost
//   done   - countdown reached zero, enables blinking
//   error  - invalid load value, forces dashes
//   seg    - active-low cathodes {dp,g,f,e,d,c,b,a}
//   an     - active-low anodes, an[i] enables digit i
module seg7_scan_driver #(
   parameter int REFRESH_DIV = 100000,
   parameter int BLINK_DIV   = 250
) (
   input  logic       clk,
   input  logic       reset,
   input  logic [3:0] D0,
   input  logic [3:0] D1,
   input  logic [3:0] D2,
   input  logic [3:0] D3,
   input  logic       done,
   input  logic       error,
   output logic [7:0] seg,
   output logic [3:0] an
);
   localparam int RW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
   localparam int BW = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
   localparam logic [RW-1:0] RC_MAX = RW'(REFRESH_DIV - 1);
   localparam logic [BW-1:0] BC_MAX = BW'(BLINK_DIV - 1);

   logic [RW-1:0] r_rc;
   logic [1:0]    r_idx;
   logic [BW-1:0] r_bc;
   logic          r_ph;
   logic [7:0]    r_seg;
   logic [3:0]    r_an;

   logic          w_adv;
   logic          w_blink_en;
   logic [3:0]    w_digit;
   logic [6:0]    w_dec;
   logic [3:0]    w_an_scan;
   logic [7:0]    w_seg_next;
   logic [3:0]    w_an_next;

   assign w_adv      = (r_rc == RC_MAX);
   assign w_blink_en = done && !error;

   // refresh counter and digit index
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_rc  <= '0;
         r_idx <= 2'd0;
      end else begin
         r_rc  <= w_adv ? '0 : r_rc + RW'(1);
         r_idx <= w_adv ? r_idx + 2'd1 : r_idx;
      end
   end

   // blink counter and phase; held at zero whenever blinking is not enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_bc <= '0;
         r_ph <= 1'b0;
      end else if (!w_blink_en) begin
         r_bc <= '0;
         r_ph <= 1'b0;
      end else if (w_adv) begin
         r_bc <= (r_bc == BC_MAX) ? '0 : r_bc + BW'(1);
         r_ph <= (r_bc == BC_MAX) ? ~r_ph : r_ph;
      end
   end

   assign w_digit = (r_idx == 2'd0) ? D0 :
                    (r_idx == 2'd1) ? D1 :
                    (r_idx == 2'd2) ? D2 : D3;

   always_comb begin
      w_dec = 7'h3F;
      case (w_digit)
         4'd0: w_dec = 7'h40;
         4'd1: w_dec = 7'h79;
         4'd2: w_dec = 7'h24;
         4'd3: w_dec = 7'h30;
         4'd4: w_dec = 7'h19;
         4'd5: w_dec = 7'h12;
         4'd6: w_dec = 7'h02;
         4'd7: w_dec = 7'h78;
         4'd8: w_dec = 7'h00;
         4'd9: w_dec = 7'h10;
         default: w_dec = 7'h3F;
      endcase
   end

   // ph can only be set while done was high, and it is cleared on the edge
   // after done falls; blanking on ph alone gives the one extra blank cycle
   // before normal digits return.
   assign w_an_scan  = ~(4'b0001 << r_idx);
   assign w_seg_next = error ? 8'hBF :
                       r_ph  ? 8'hFF : {r_idx != 2'd2, w_dec};
   assign w_an_next  = (!error && r_ph) ? 4'b1111 : w_an_scan;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_seg <= 8'hFF;
         r_an  <= 4'b1111;
      end else begin
         r_seg <= w_seg_next;
         r_an  <= w_an_next;
      end
   end

   assign seg = r_seg;
   assign an  = r_an;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: directed self-checking bench for seg7_scan_driver.
module tb_seg7_scan_driver;
   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [3:0] D0 = 4'd4, D1 = 4'd3, D2 = 4'd2, D3 = 4'd1;
   logic       done = 1'b0, error = 1'b0;
   logic [7:0] seg;
   logic [3:0] an;

   int checks = 0;
   int failures = 0;
   int n = 0;

   logic [6:0] dec [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h3F};
   logic [3:0] anode [4] = '{4'b1110, 4'b1101, 4'b1011, 4'b0111};
   logic [11:0] scan_exp [4] = '{{4'b1110, 8'h99}, {4'b1101, 8'hB0},
                                 {4'b1011, 8'h24}, {4'b0111, 8'hF9}};

   seg7_scan_driver #(.REFRESH_DIV(4), .BLINK_DIV(2)) dut (
      .clk(clk), .reset(reset), .D0(D0), .D1(D1), .D2(D2), .D3(D3),
      .done(done), .error(error), .seg(seg), .an(an)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog");
   end

   // digit shown on the next edge, counting edges since reset release
   function automatic int nd();
      return (n / 4) % 4;
   endfunction

   task automatic step();
      @(posedge clk);
      @(negedge clk);
      n++;
   endtask

   task automatic chk(input string tag, input logic [11:0] exp);
      checks++;
      assert ({an, seg} === exp) else begin
         failures++;
         $error("FAIL %s: observed %h expected %h", tag, {an, seg}, exp);
      end
   endtask

   initial begin
      #2 reset = 1'b0;
      #1 chk("reset_async", {4'b1111, 8'hFF});
      @(negedge clk);
      @(negedge clk);
      chk("reset_held", {4'b1111, 8'hFF});
      reset = 1'b1;
      n = 0;
      // normal scan 1,2,3,4
      for (int i = 0; i < 16; i++) begin
         step();
         chk($sformatf("scan%0d", i), scan_exp[i / 4]);
      end
      // decode sweep on digit 0
      for (int v = 0; v < 16; v++) begin
         while (nd() != 0) step();
         D0 = 4'(v);
         step();
         chk($sformatf("dec%0d", v), {4'b1110, 1'b1, dec[v]});
      end
      D0 = 4'd4;
      // error: dashes on every digit while scanning
      error = 1'b1;
      for (int i = 0; i < 8; i++) begin
         int d;
         d = nd();
         step();
         chk($sformatf("err%0d", i), {anode[d], 8'hBF});
      end
      error = 1'b0;
      begin
         int d;
         d = nd();
         step();
         chk("err_release", scan_exp[d]);
      end
      // done blinking, aligned to start of a digit period
      while (n % 4 != 0) step();
      done = 1'b1;
      for (int i = 0; i < 26; i++) begin
         int d;
         d = nd();
         step();
         chk($sformatf("blink%0d", i), ((i / 8) % 2 == 1) ? {4'b1111, 8'hFF} : scan_exp[d]);
      end
      // deassert during blank: one more blank cycle, then visible
      done = 1'b0;
      step();
      chk("done_fall_blank", {4'b1111, 8'hFF});
      begin
         int d;
         d = nd();
         step();
         chk("done_fall_vis", scan_exp[d]);
      end
      // error asserted mid-blink clears phase and shows dashes
      while (n % 4 != 0) step();
      done = 1'b1;
      for (int i = 0; i < 9; i++) step();
      chk("midblink_blank", {4'b1111, 8'hFF});
      error = 1'b1;
      begin
         int d;
         d = nd();
         step();
         chk("midblink_err", {anode[d], 8'hBF});
      end
      error = 1'b0;
      begin
         int d;
         d = nd();
         step();
         chk("midblink_resume", scan_exp[d]);
      end
      done = 1'b0;
      step();
      // reset mid digit 2
      while (nd() != 2) step();
      step();
      step();
      chk("pre_reset_d2", scan_exp[2]);
      reset = 1'b0;
      #1 chk("midreset_async", {4'b1111, 8'hFF});
      @(negedge clk);
      chk("midreset_held", {4'b1111, 8'hFF});
      reset = 1'b1;
      n = 0;
      for (int i = 0; i < 5; i++) begin
         step();
         chk($sformatf("restart%0d", i), scan_exp[i / 4]);
      end
      // D1 change while digit 1 is lit
      D1 = 4'd5;
      while (nd() != 1) step();
      step();
      chk("d1_5", {4'b1101, 8'h92});
      D1 = 4'd7;
      step();
      chk("d1_7", {4'b1101, 8'hF8});
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
